// File: rtl/channelizer_pkg.sv
// channelizer_pkg: shared types, defaults and helpers for the channelizer sequencer
package channelizer_pkg;
    localparam int FFT_LEN       = 1024;
    localparam int MAX_AVGS_LOG2 = 16;
    localparam int FRAME_CNT_W   = 32;

    typedef logic [7:0] n_avgs_t;

    typedef enum logic [1:0] {IDLE, SYNC, ACCUM} state_t;

    function automatic n_avgs_t clamp_n_avgs(input n_avgs_t n, input int max_log2);
        return (int'(n) > max_log2) ? n_avgs_t'(max_log2) : n;
    endfunction
endpackage

// File: rtl/channelizer_result_hs.sv
// channelizer_result_hs: holds finished averages for the packetizer and tracks overruns
module channelizer_result_hs #(
    parameter int FRAME_CNT_W = channelizer_pkg::FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dp_valid,
    input  logic                   pkt_ready,
    input  logic                   err_clr,
    output logic                   pkt_valid,
    output logic [FRAME_CNT_W-1:0] pkt_seq,
    output logic                   overflow
);
    logic                   pkt_valid_q, pkt_valid_d, overflow_q, overflow_d, accept;
    logic [FRAME_CNT_W-1:0] seq_q, seq_d;

    // A new result is offered unless one is already waiting unaccepted; then it is dropped and flagged
    always_comb begin
        accept      = pkt_valid_q & pkt_ready;
        pkt_valid_d = dp_valid | (pkt_valid_q & ~accept);
        seq_d       = accept ? seq_q + FRAME_CNT_W'(1) : seq_q;
        overflow_d  = (dp_valid & pkt_valid_q & ~pkt_ready) | (overflow_q & ~err_clr);
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_valid_q <= 1'b0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pkt_valid_q <= pkt_valid_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_seq   = seq_q;
    assign overflow  = overflow_q;
endmodule

// File: rtl/channelizer_ctrl.sv
// channelizer_ctrl: frame/average sequencer driving the averaging datapath strobes
module channelizer_ctrl #(
    parameter int FFT_LEN       = channelizer_pkg::FFT_LEN,
    parameter int MAX_AVGS_LOG2 = channelizer_pkg::MAX_AVGS_LOG2,
    parameter int FRAME_CNT_W   = channelizer_pkg::FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   cfg_wr,
    input  logic [7:0]             cfg_n_avgs,
    input  logic                   fft_valid,
    input  logic                   fft_last,
    output logic                   acc_en,
    output logic                   acc_first,
    output logic                   acc_dump,
    input  logic                   dp_valid,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [FRAME_CNT_W-1:0] pkt_seq,
    output logic [7:0]             active_n_avgs,
    output logic                   sync_err,
    output logic                   overflow,
    input  logic                   err_clr
);
    import channelizer_pkg::*;

    localparam int SW = $clog2(FFT_LEN);
    localparam int FW = MAX_AVGS_LOG2 + 1;
    localparam logic [SW-1:0] SAMP_MAX = SW'(FFT_LEN - 1);
    localparam logic [SW-1:0] SAMP_ONE = SW'(1);
    localparam logic [FW-1:0] FRM_ONE  = FW'(1);

    state_t        state_q, state_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d, frm_tgt;
    n_avgs_t       active_q, active_d, pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d, sync_err_q, sync_err_d;
    logic          bad, boundary;

    // Strobes are zero-latency; a misaligned frame edge suppresses the dump it would have produced
    always_comb begin
        frm_tgt   = (FRM_ONE << active_q) - FRM_ONE;
        acc_en    = fft_valid & (state_q == ACCUM);
        bad       = acc_en & (fft_last ? samp_cnt_q != SAMP_MAX : samp_cnt_q == SAMP_MAX);
        acc_first = acc_en & (frm_cnt_q == '0);
        acc_dump  = acc_en & fft_last & (frm_cnt_q == frm_tgt) & ~bad;
    end

    // Frame FSM; boundary marks the cycle where frm_cnt returns to 0 and pending config may apply
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        boundary   = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = SYNC;
            SYNC: if (fft_valid & fft_last) begin
                state_d    = ACCUM;
                samp_cnt_d = '0;
                frm_cnt_d  = '0;
                boundary   = 1'b1;
            end
            ACCUM: if (bad) state_d = SYNC;
            else if (acc_en) begin
                samp_cnt_d = samp_cnt_q + SAMP_ONE;
                if (fft_last) begin
                    frm_cnt_d = acc_dump ? '0 : frm_cnt_q + FRM_ONE;
                    boundary  = acc_dump;
                    if (!enable) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d     = cfg_wr ? clamp_n_avgs(cfg_n_avgs, MAX_AVGS_LOG2) : pend_q;
        pend_vld_d = cfg_wr | (pend_vld_q & ~boundary);
        active_d   = (boundary & pend_vld_q & ~cfg_wr) ? pend_q : active_q;
        sync_err_d = bad | (sync_err_q & ~err_clr);
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            frm_cnt_q  <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign active_n_avgs = active_q;
    assign sync_err      = sync_err_q;

    channelizer_result_hs #(.FRAME_CNT_W(FRAME_CNT_W)) u_hs (
        .clk       (clk),
        .rst       (rst),
        .dp_valid  (dp_valid),
        .pkt_ready (pkt_ready),
        .err_clr   (err_clr),
        .pkt_valid (pkt_valid),
        .pkt_seq   (pkt_seq),
        .overflow  (overflow)
    );
endmodule

// File: tb/tb_channelizer_ctrl.sv
// tb_channelizer_ctrl: scoreboard bench for channelizer_ctrl with FFT_LEN=8
module tb_channelizer_ctrl;
    logic        clk, rst, enable, cfg_wr, fft_valid, fft_last, dp_valid, pkt_ready, err_clr;
    logic [7:0]  cfg_n_avgs, active_n_avgs;
    logic        acc_en, acc_first, acc_dump, pkt_valid, sync_err, overflow;
    logic [31:0] pkt_seq;

    logic [2:0]  exp_q[$];
    logic [31:0] pkt_q[$];
    logic [2:0]  e;
    logic [31:0] s;
    int          n_cmp = 0;
    int          n_bad = 0;

    channelizer_ctrl #(.FFT_LEN(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_wr(cfg_wr), .cfg_n_avgs(cfg_n_avgs),
        .fft_valid(fft_valid), .fft_last(fft_last), .acc_en(acc_en), .acc_first(acc_first),
        .acc_dump(acc_dump), .dp_valid(dp_valid), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_seq(pkt_seq), .active_n_avgs(active_n_avgs), .sync_err(sync_err),
        .overflow(overflow), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected strobes per sample and expected sequence per acceptance
    always @(negedge clk) begin
        if (!rst) begin
            if (fft_valid) begin
                if (exp_q.size() == 0) chk("strobe_queue_empty", 32'(exp_q.size()), 32'd1);
                else begin
                    e = exp_q.pop_front();
                    chk("strobes{en,first,dump}", 32'({acc_en, acc_first, acc_dump}), 32'(e));
                end
            end else chk("strobes_without_valid", 32'({acc_en, acc_first, acc_dump}), 32'd0);
            if (pkt_valid && pkt_ready) begin
                if (pkt_q.size() == 0) chk("pkt_queue_empty", 32'(pkt_q.size()), 32'd1);
                else begin
                    s = pkt_q.pop_front();
                    chk("pkt_seq_on_accept", pkt_seq, s);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        cfg_wr    = 1'b0;
    endtask

    task automatic samp(input bit last, input bit en, input bit first, input bit dump);
        fft_valid = 1'b1;
        fft_last  = last;
        exp_q.push_back({en, first, dump});
        tick();
    endtask

    task automatic frame(input int len, input bit en, input bit first, input bit dump, input bit cw);
        for (int i = 0; i < len; i++) begin
            if (cw && i == len - 1) begin
                cfg_wr     = 1'b1;
                cfg_n_avgs = 8'd40;
            end
            samp(i == len - 1, en, first, dump && i == len - 1);
        end
        quiet();
    endtask

    task automatic pkt(input logic [31:0] seq);
        dp_valid  = 1'b1;
        pkt_ready = 1'b1;
        pkt_q.push_back(seq);
        tick();
        dp_valid = 1'b0;
        tick();
        tick();
        pkt_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_wr = 1'b0; cfg_n_avgs = '0; fft_valid = 1'b0;
        fft_last = 1'b0; dp_valid = 1'b0; pkt_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_pkt_valid", 32'(pkt_valid), 0);
        chk("rst_pkt_seq", pkt_seq, 0);
        chk("rst_active", 32'(active_n_avgs), 0);
        chk("rst_flags", 32'({sync_err, overflow}), 0);
        rst = 1'b0;
        // n_avgs=2: four frames, first on frame 0, dump on sample 31
        cfg_wr = 1'b1; cfg_n_avgs = 8'd2; enable = 1'b1;
        tick();
        cfg_wr = 1'b0;
        samp(1, 0, 0, 0);
        quiet();
        chk("active_after_sync", 32'(active_n_avgs), 2);
        frame(8, 1, 1, 0, 0);
        frame(8, 1, 0, 0, 0);
        frame(8, 1, 0, 0, 0);
        frame(8, 1, 0, 1, 0);
        tick(); tick();
        chk("pkt_valid_before_dp", 32'(pkt_valid), 0);
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        chk("pkt_valid_latency", 32'(pkt_valid), 1);
        chk("pkt_seq_first", pkt_seq, 0);
        pkt_q.push_back(0);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        chk("pkt_valid_after_accept", 32'(pkt_valid), 0);
        chk("seq_after_accept", pkt_seq, 1);
        // disable on a non-dumping frame drops it; pending n_avgs=0 applies on resync
        cfg_wr = 1'b1; cfg_n_avgs = 8'd0; enable = 1'b0;
        tick();
        cfg_wr = 1'b0;
        frame(8, 1, 1, 0, 0);
        tick();
        chk("active_kept_on_drop", 32'(active_n_avgs), 2);
        enable = 1'b1;
        tick();
        samp(1, 0, 0, 0);
        quiet();
        chk("active_n0", 32'(active_n_avgs), 0);
        for (int k = 1; k <= 3; k++) begin
            frame(8, 1, 1, 1, 0);
            pkt(k);
        end
        chk("seq_after_three", pkt_seq, 4);
        // config changes only on average boundaries
        cfg_wr = 1'b1; cfg_n_avgs = 8'd1;
        tick();
        quiet();
        frame(8, 1, 1, 1, 0);
        chk("active_1", 32'(active_n_avgs), 1);
        pkt(4);
        frame(8, 1, 1, 0, 0);
        cfg_wr = 1'b1; cfg_n_avgs = 8'd3;
        tick();
        quiet();
        chk("active_mid_avg", 32'(active_n_avgs), 1);
        frame(8, 1, 0, 1, 0);
        chk("active_3", 32'(active_n_avgs), 3);
        pkt(5);
        cfg_wr = 1'b1; cfg_n_avgs = 8'd5;
        tick();
        quiet();
        frame(8, 1, 1, 0, 0);
        for (int k = 0; k < 6; k++) frame(8, 1, 0, 0, 0);
        frame(8, 1, 0, 1, 1);
        chk("cfg_wr_wins_boundary", 32'(active_n_avgs), 3);
        pkt(6);
        enable = 1'b0;
        frame(8, 1, 1, 0, 0);
        tick();
        enable = 1'b1;
        tick();
        samp(1, 0, 0, 0);
        quiet();
        chk("active_clamped", 32'(active_n_avgs), 16);
        // overrun: second result dropped, first still offered
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        chk("ovf_valid", 32'(pkt_valid), 1);
        chk("ovf_flag_pre", 32'(overflow), 0);
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_seq_held", pkt_seq, 7);
        chk("ovf_valid_held", 32'(pkt_valid), 1);
        pkt_q.push_back(7);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        tick();
        chk("ovf_single_accept", 32'(pkt_valid), 0);
        chk("ovf_seq_after", pkt_seq, 8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        // same-cycle dp_valid and acceptance
        dp_valid = 1'b1;
        tick();
        pkt_q.push_back(8);
        pkt_q.push_back(9);
        pkt_ready = 1'b1;
        tick();
        dp_valid = 1'b0;
        chk("valid_held_accept_dp", 32'(pkt_valid), 1);
        chk("seq_accept_dp", pkt_seq, 9);
        tick();
        pkt_ready = 1'b0;
        chk("valid_drained", 32'(pkt_valid), 0);
        chk("seq_10", pkt_seq, 10);
        // reset mid-ACCUM with a result pending
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        samp(0, 1, 1, 0);
        samp(0, 1, 1, 0);
        quiet();
        rst = 1'b1;
        tick();
        chk("rst2_pkt_valid", 32'(pkt_valid), 0);
        chk("rst2_pkt_seq", pkt_seq, 0);
        chk("rst2_active", 32'(active_n_avgs), 0);
        fft_valid = 1'b1;
        #1;
        chk("rst2_acc_en", 32'(acc_en), 0);
        fft_valid = 1'b0;
        rst = 1'b0;
        tick();
        frame(8, 0, 0, 0, 0);
        frame(8, 1, 1, 1, 0);
        // sync errors with n_avgs=0 so a dump would otherwise fire
        frame(6, 1, 1, 0, 0);
        chk("sync_err_early_last", 32'(sync_err), 1);
        frame(8, 0, 0, 0, 0);
        frame(8, 1, 1, 1, 0);
        chk("sync_err_sticky", 32'(sync_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("sync_err_cleared", 32'(sync_err), 0);
        for (int k = 0; k < 8; k++) samp(0, 1, 1, 0);
        samp(1, 0, 0, 0);
        quiet();
        chk("sync_err_missing_last", 32'(sync_err), 1);
        tick();
        chk("strobe_queue_drained", 32'(exp_q.size()), 0);
        chk("pkt_queue_drained", 32'(pkt_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/channelizer_ctrl.md
Name: channelizer_ctrl

Overview:
Sequencer for the N-bin averaging channelizer datapath. It tracks FFT frame boundaries and counts 2^n_avgs frames per average. It drives the datapath's accumulate, clear and dump strobes, and applies N_AVGS changes only on average boundaries. It also hands finished averages to the downstream packetizer over a valid/ready handshake, and flags frame-sync errors and result overruns.

Parameters:
FFT_LEN, 1024, samples per FFT frame (power of 2, >= 4)
MAX_AVGS_LOG2, 16, maximum log2 frame count per average; larger requests are clamped to this value
FRAME_CNT_W, 32, width of the emitted-average counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run/stop control
cfg_wr  in  1  one-cycle strobe that captures cfg_n_avgs
cfg_n_avgs  in  8  requested log2 of the averages per output
fft_valid  in  1  FFT sample valid
fft_last  in  1  last sample of an FFT frame; qualified by fft_valid
acc_en  out  1  datapath accumulate enable, aligned with the sample
acc_first  out  1  first frame of an average; datapath overwrites instead of summing
acc_dump  out  1  last sample of the last frame; datapath latches and emits
dp_valid  in  1  datapath result-ready pulse, arriving some cycles after acc_dump
pkt_valid  out  1  an average is available downstream
pkt_ready  in  1  downstream accept
pkt_seq  out  FRAME_CNT_W  sequence number of the average currently offered
active_n_avgs  out  8  n_avgs value in force (post-clamp)
sync_err  out  1  sticky frame-alignment error
overflow  out  1  sticky result-overrun flag
err_clr  in  1  clears sync_err and overflow

Behaviour:
- Reset values: every output is 0. Internal state after reset: state=IDLE, all counters 0, pending cfg=0, pending-valid=0.
- Registers: samp_cnt (log2 FFT_LEN bits), frm_cnt (MAX_AVGS_LOG2+1 bits), seq (FRAME_CNT_W bits).
- FSM states:
  - IDLE: waits for enable=1, then goes to SYNC.
  - SYNC: waits for fft_valid&fft_last, then sets samp_cnt=0 and frm_cnt=0 and goes to ACCUM. No accumulation strobes are issued in SYNC.
  - ACCUM: normal running state.
- Strobes are combinational from registered state and the fft_valid/fft_last inputs (zero latency):
  - acc_en = fft_valid & (state==ACCUM).
  - acc_first = acc_en & (frm_cnt==0).
  - acc_dump = acc_en & fft_last & (frm_cnt == 2^active_n_avgs - 1).
- ACCUM counting:
  - samp_cnt increments on acc_en and wraps after FFT_LEN-1.
  - On fft_last, frm_cnt increments; after a dump it wraps to 0.
- Config handling:
  - cfg_wr loads the pending register with min(cfg_n_avgs, MAX_AVGS_LOG2) and sets pending-valid.
  - The pending value transfers to active_n_avgs at the frame boundary where frm_cnt becomes 0, i.e. in the cycle after acc_dump or on SYNC exit.
  - A cfg_wr in that same cycle wins: the new value stays pending until the next boundary.
- n_avgs=0 case: every frame is both first and dump; acc_first and acc_dump coincide on the last sample.
- Sync error detection, in ACCUM only:
  - fft_last with samp_cnt != FFT_LEN-1, or fft_valid with samp_cnt==FFT_LEN-1 and no fft_last, is an error.
  - Response: set sync_err, suppress acc_dump in that cycle, go to SYNC. The partial average is discarded and the next acc_first clears the datapath.
- Disable: enable=0 during ACCUM is honoured at the next fft_last.
  - If that frame would dump, acc_dump is still issued and the result is delivered.
  - Otherwise no dump is issued and the partial average is dropped.
  - The FSM then goes to IDLE.
- Result handshake:
  - dp_valid sets pkt_valid on the next cycle.
  - pkt_valid stays high until the cycle where pkt_valid&pkt_ready.
  - On acceptance, seq increments (wraps at 2^FRAME_CNT_W); pkt_seq shows seq while pkt_valid is high.
  - Same-cycle dp_valid and acceptance: pkt_valid stays 1 and seq increments.
- Overrun: dp_valid while pkt_valid=1 and pkt_ready=0 sets overflow. The new result is dropped and the old one continues to be offered.
- err_clr clears both sticky flags in the next cycle; a simultaneous set takes priority over the clear.
- rst in any state returns everything to reset values next cycle, including dropping pkt_valid.

Decomposition:
- Shared package channelizer_pkg:
  - FSM state enum: IDLE, SYNC, ACCUM.
  - Default constants: FFT_LEN, MAX_AVGS_LOG2, FRAME_CNT_W.
  - Typedef n_avgs_t (8-bit).
- Natural sub-module: channelizer_result_hs. It holds the pkt_valid/seq register, the overflow logic and the dp_valid capture, keeping the handshake separate from the frame FSM.

Test Plan:
- FFT_LEN=8, cfg_n_avgs=2, enable, 4 clean frames → acc_first high on samples 0–7 of frame 0 only; one acc_dump on sample 31; pkt_valid one cycle after dp_valid; pkt_seq=0.
- n_avgs=0, 3 frames, pkt_ready=1 → acc_first & acc_dump together on each fft_last; 3 accepts; seq ends at 3.
- cfg_wr with 3 mid-average while active=1 → active_n_avgs changes only after the current 2-frame dump; next dump lands 8 frames later. cfg_n_avgs=40 → active_n_avgs=16.
- fft_last at samp_cnt=5 → sync_err=1, no dump, FSM in SYNC until the next fft_last. err_clr → sync_err=0.
- pkt_ready=0, two dp_valid pulses → overflow=1, pkt_seq unchanged, first result still offered. Then pkt_ready=1 → one accept.
- rst asserted mid-ACCUM with pkt_valid=1 → all outputs 0 next cycle; re-enable resynchronises via SYNC.
